// File: rtl/pipe_buffer.sv
// Ready/valid FIFO buffer of DEPTH entries with one-cycle latency, flush, and a flushed pulse.
// Handshake outputs come only from registered state, so out_ready never reaches in_ready.
module pipe_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  flushed
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  flushed_q;
    logic                  push;
    logic                  pop;

    assign in_ready  = (count_q < CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign count     = count_q;
    assign flushed   = flushed_q;

    // Control stage: pointers, occupancy and flush indication
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            flushed_q <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            flushed_q <= out_valid;
        end else begin
            flushed_q <= 1'b0;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage stage: contents survive rst and flush; validity lives in the pointers
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_pipe_buffer.sv
// Directed self-checking bench for pipe_buffer at DATA_WIDTH=32, DEPTH=2.
module tb_pipe_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;
    logic        flushed;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_buffer #(.DATA_WIDTH(32), .DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count),
        .flushed(flushed)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int sent;
        int recv;
        int maxc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_flushed",   32'(flushed),   32'd0);

        // Basic transfer
        push_one(32'hDEADBEEF);
        check("basic_out_valid", 32'(out_valid), 32'd1);
        check("basic_out_data",  out_data,       32'hDEADBEEF);
        check("basic_count",     32'(count),     32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("basic_drain_count", 32'(count),     32'd0);
        check("basic_drain_valid", 32'(out_valid), 32'd0);
        check("basic_drain_data",  out_data,       32'd0);

        // Empty buffer ignores out_ready
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);

        // Fill and backpressure
        push_one(32'h1);
        push_one(32'h2);
        check("full_count",    32'(count),    32'd2);
        check("full_in_ready", 32'(in_ready), 32'd0);
        push_one(32'h3);
        check("full_hold_count", 32'(count), 32'd2);
        check("full_hold_data",  out_data,   32'h1);
        out_ready = 1'b1;
        check("bp_first", out_data, 32'h1);
        step();
        check("bp_second", out_data,   32'h2);
        check("bp_cnt1",   32'(count), 32'd1);
        step();
        out_ready = 1'b0;
        check("bp_empty_count", 32'(count),     32'd0);
        check("bp_no_third",    32'(out_valid), 32'd0);

        // Simultaneous push and pop
        push_one(32'hA);
        check("sim_pre_data", out_data, 32'hA);
        in_valid = 1'b1; in_data = 32'hB; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("sim_count", 32'(count), 32'd1);
        check("sim_data",  out_data,   32'hB);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush with held entries and a competing push
        push_one(32'h21);
        push_one(32'h22);
        check("fl_pre_count", 32'(count), 32'd2);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h5;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count",     32'(count),     32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_data",  out_data,       32'd0);
        check("fl_flushed",   32'(flushed),   32'd1);
        step();
        check("fl_flushed_drop", 32'(flushed),   32'd0);
        check("fl_no_5",         32'(out_valid), 32'd0);

        // Flush of an empty buffer does not pulse flushed
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_empty_flushed", 32'(flushed), 32'd0);

        // Pointer wrap with toggling out_ready
        sent = 0; recv = 0; maxc = 0;
        for (int cyc = 0; cyc < 80 && recv < 10; cyc++) begin
            in_valid  = (sent < 10);
            in_data   = 32'h10 + 32'(sent);
            out_ready = cyc[0];
            if (out_valid && out_ready) begin
                check("wrap_data", out_data, 32'h10 + 32'(recv));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            step();
            if (int'(count) > maxc) maxc = int'(count);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("wrap_recv",   32'(recv), 32'd10);
        check("wrap_maxcnt", 32'(maxc <= 2), 32'd1);
        check("wrap_empty",  32'(count), 32'd0);

        // Reset beats flush and suppresses flushed
        push_one(32'h31);
        push_one(32'h32);
        check("rp_pre_count", 32'(count), 32'd2);
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        check("rp_count",     32'(count),     32'd0);
        check("rp_in_ready",  32'(in_ready),  32'd1);
        check("rp_flushed",   32'(flushed),   32'd0);
        check("rp_out_valid", 32'(out_valid), 32'd0);
        check("rp_out_data",  out_data,       32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_buffer.md
PIPE_BUFFER -- requirements
Module: pipe_buffer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits (legal values 1 or more).
REQ-002 The module SHALL have parameter DEPTH, default 2, giving the number of storage entries (legal values 1 or more).
REQ-003 The module SHALL have parameter CNT_WIDTH, default $clog2(DEPTH+1), giving the occupancy counter width.
REQ-004 The module SHALL use one clock, clk, and a synchronous, active-high reset, rst.
REQ-005 The module SHALL have these ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  producer offers in_data
- in_ready  output  1  buffer can accept an entry
- in_data  input  DATA_WIDTH  payload from producer
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  consumer takes out_data
- out_data  output  DATA_WIDTH  oldest held entry
- count  output  CNT_WIDTH  number of entries held
- flushed  output  1  one-cycle pulse: the previous edge discarded at least one entry

Function
REQ-006 Storage SHALL be a DEPTH-entry circular buffer with a write pointer and a read pointer; each pointer SHALL wrap from DEPTH-1 to 0.
REQ-007 A push SHALL occur on a rising edge where in_valid=1, in_ready=1 and flush=0.
REQ-008 A pop SHALL occur on a rising edge where out_valid=1, out_ready=1 and flush=0.
REQ-009 in_ready SHALL be 1 exactly when count<DEPTH, derived only from registered state, with no combinational path from out_ready.
REQ-010 out_valid SHALL be 1 exactly when count!=0, derived only from registered state.
REQ-011 out_data SHALL equal the entry at the read pointer when out_valid=1, and SHALL be all zeros when out_valid=0.
REQ-012 Latency SHALL be one cycle: an entry pushed into an empty buffer at edge N SHALL appear on out_data with out_valid=1 in the cycle after edge N.
REQ-013 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-014 A push alone SHALL increment count by 1; a pop alone SHALL decrement count by 1.
REQ-015 Entries SHALL leave in first-in first-out order with no loss or duplication.
REQ-016 When full (count=DEPTH), in_ready=0: in_data SHALL be ignored, and stored data and count SHALL stay unchanged unless a pop occurs.
REQ-017 When empty, out_ready SHALL have no effect.
REQ-018 flush=1 at an edge SHALL set count to 0 and both pointers to 0, and SHALL discard any push or pop offered in that cycle; flush SHALL take priority over push and pop.
REQ-019 flushed SHALL be 1 for exactly the one cycle after an edge where flush=1 and count was not 0; otherwise flushed SHALL be 0.
REQ-020 Stored entry contents SHALL NOT be cleared by flush or rst; only the pointers and count define validity.
REQ-021 When DEPTH=1, the module SHALL behave as a plain pipeline register with in_ready=!out_valid.

Reset
REQ-022 rst=1 at an edge SHALL set count=0, both pointers to 0 and flushed=0, giving out_valid=0, out_data=0 and in_ready=1 from the next cycle.
REQ-023 rst SHALL take priority over flush, push and pop.
REQ-024 An rst asserted mid-stream SHALL discard all held entries without asserting flushed.

Verification
REQ-025 The bench SHALL cover basic transfer (DATA_WIDTH=32, DEPTH=2): push 0xDEADBEEF into an empty buffer at edge N -> in cycle N+1, out_valid=1, out_data=0xDEADBEEF, count=1.
REQ-026 The bench SHALL cover fill and backpressure: with out_ready=0, push 0x1 then 0x2 -> count=2 and in_ready=0; offer 0x3 -> count stays 2; then out_ready=1 -> outputs 0x1, then 0x2, never 0x3.
REQ-027 The bench SHALL cover simultaneous push and pop: with count=1 holding 0xA, push 0xB while popping -> count stays 1 and out_data=0xB on the next cycle.
REQ-028 The bench SHALL cover flush with a held entry: with count=2, flush=1 together with in_valid=1 (0x5) -> next cycle count=0, out_valid=0, out_data=0, flushed=1; flushed=0 one cycle later; 0x5 is never output.
REQ-029 The bench SHALL cover pointer wrap: stream 10 entries 0x10..0x19 with out_ready toggling every cycle -> outputs are exactly 0x10..0x19 in order, and count never exceeds 2.
REQ-030 The bench SHALL cover reset priority: with count=2, assert rst=1 and flush=1 together -> next cycle count=0, in_ready=1, flushed=0.
